// File: rtl/cdb_rr_arbiter_pkg.sv
// cdb_rr_arbiter_pkg: shared CDB packet type and requester index constants
package cdb_rr_arbiter_pkg;
  localparam int N_CDB_REQ = 5;
  localparam int ROB_TAG_W = 5;
  typedef enum logic [2:0] {REQ_ADD0, REQ_ADD1, REQ_MULT, REQ_DIV, REQ_MEM} cdb_req_e;
  typedef struct packed {
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [31:0]          value;
  } CDB_packet_t;
endpackage

// File: rtl/cdb_rr_arbiter_rr_pick.sv
// rr_pick: rotate-priority encoder, first request at or after ptr (mod N) wins
module rr_pick #(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);
  logic [W:0] s;
  always_comb begin
    idx = ptr;
    any = 1'b0;
    s = '0;
    // scan farthest offset first so the offset nearest ptr is the last write
    for (int k = N - 1; k >= 0; k--) begin
      s = {1'b0, ptr} + (W+1)'(k);
      s = (s >= (W+1)'(N)) ? s - (W+1)'(N) : s;
      if (req[s[W-1:0]]) begin
        any = 1'b1;
        idx = s[W-1:0];
      end
    end
    gnt = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/cdb_rr_arbiter.sv
// cdb_rr_arbiter: round-robin arbiter driving a registered common data bus
module cdb_rr_arbiter
  import cdb_rr_arbiter_pkg::*;
#(
  parameter int N_REQ = N_CDB_REQ,
  parameter int PTR_W = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [N_REQ-1:0]               valid_out_bus,
  input  CDB_packet_t [N_REQ-1:0]        req_packet,
  output logic [N_REQ-1:0]               yummi_in_bus,
  output CDB_packet_t                    new_CDB,
  output logic                           cdb_valid,
  output logic [PTR_W-1:0]               grant_idx
);
  logic [PTR_W-1:0] rr_ptr, idx, nxt;
  logic [N_REQ-1:0] gnt;
  logic             any, grant;
  CDB_packet_t      cdb_q;
  logic             cdb_v_q;
  rr_pick #(.N(N_REQ), .W(PTR_W)) u_pick (
    .req(valid_out_bus),
    .ptr(rr_ptr),
    .gnt(gnt),
    .idx(idx),
    .any(any)
  );
  always_comb begin
    grant        = any & ~reset & ~flush;
    yummi_in_bus = grant ? gnt : '0;
    grant_idx    = grant ? idx : rr_ptr;
    nxt          = (idx == PTR_W'(N_REQ - 1)) ? '0 : idx + PTR_W'(1);
  end
  // a cleared cdb_q keeps stale ROB tags off the bus when nothing is granted
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr  <= '0;
      cdb_q   <= '0;
      cdb_v_q <= 1'b0;
    end else begin
      rr_ptr  <= flush ? '0 : grant ? nxt : rr_ptr;
      cdb_q   <= grant ? req_packet[idx] : '0;
      cdb_v_q <= grant;
    end
  end
  assign new_CDB   = cdb_q;
  assign cdb_valid = cdb_v_q;
endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// tb_cdb_rr_arbiter: directed and random scoreboard checks of the CDB arbiter
module tb_cdb_rr_arbiter;
  import cdb_rr_arbiter_pkg::*;
  localparam int N = 5;
  logic                clk = 1'b0;
  logic                reset, flush;
  logic [N-1:0]        valid_out_bus;
  CDB_packet_t [N-1:0] req_packet;
  logic [N-1:0]        yummi_in_bus;
  CDB_packet_t         new_CDB;
  logic                cdb_valid;
  logic [2:0]          grant_idx;
  int                  n_chk = 0, n_fail = 0;
  int                  ptr = 0;
  bit                  live = 0;
  CDB_packet_t         exp_q[$];
  int                  n_yumi = 0, n_cdbv = 0;

  cdb_rr_arbiter #(.N_REQ(N), .PTR_W(3)) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .valid_out_bus(valid_out_bus),
    .req_packet(req_packet),
    .yummi_in_bus(yummi_in_bus),
    .new_CDB(new_CDB),
    .cdb_valid(cdb_valid),
    .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one clock: drive, compare against model/scoreboard, advance model, step edge
  task automatic cycle(input logic [N-1:0] v, input logic fl, input logic rs);
    int w;
    CDB_packet_t e;
    valid_out_bus = v;
    flush = fl;
    reset = rs;
    #1;
    if (live) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cdb_valid", 64'(cdb_valid), 64'd1);
        chk("new_CDB", 64'(new_CDB), 64'(e));
      end else begin
        chk("cdb_valid_idle", 64'(cdb_valid), 64'd0);
        chk("new_CDB_zero", 64'(new_CDB), 64'd0);
      end
    end
    w = -1;
    if (!fl && !rs)
      for (int k = 0; k < N; k++)
        if (w < 0 && v[(ptr + k) % N]) w = (ptr + k) % N;
    chk("yumi", 64'(yummi_in_bus), (w >= 0) ? 64'd1 << w : 64'd0);
    if (live) chk("grant_idx", 64'(grant_idx), 64'((w >= 0) ? w : ptr));
    if (w >= 0) exp_q.push_back(req_packet[w]);
    ptr = (rs || fl) ? 0 : (w >= 0) ? (w + 1) % N : ptr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pend_wait[N];
    int max_wait;
    logic [N-1:0] pend;
    reset = 1'b1;
    flush = 1'b0;
    valid_out_bus = '0;
    for (int i = 0; i < N; i++) req_packet[i] = '{rob_tag: 5'(i), value: 32'hA000_0000 + i};
    @(posedge clk);
    #1;
    cycle(5'b11111, 0, 1);
    live = 1;
    cycle(5'b11111, 0, 1);
    repeat (3) cycle(5'b00000, 0, 0);
    // all requesting: 0,1,2,3,4,0
    repeat (6) cycle(5'b11111, 0, 0);
    // ptr 1 -> grant mult alone -> ptr 3, then wrap to 0 then 1
    cycle(5'b00100, 0, 0);
    cycle(5'b00011, 0, 0);
    cycle(5'b00010, 0, 0);
    cycle(5'b00000, 0, 0);
    chk("ptr_after_wrap", 64'(grant_idx), 64'd2);
    // mult alone with ROB tag 7
    req_packet[REQ_MULT].rob_tag = 5'd7;
    cycle(5'b00100, 0, 0);
    chk("mult_tag", 64'(new_CDB.rob_tag), 64'd7);
    cycle(5'b00000, 0, 0);
    cycle(5'b00000, 0, 0);
    // flush with mem requesting, then mem granted
    cycle(5'b10000, 1, 0);
    cycle(5'b00000, 0, 0);
    chk("ptr_after_flush", 64'(grant_idx), 64'd0);
    cycle(5'b10000, 0, 0);
    // flush does not suppress an already-broadcasting word
    cycle(5'b00010, 0, 0);
    cycle(5'b00100, 1, 0);
    cycle(5'b00100, 0, 0);
    // mid-operation reset, with flush also high
    repeat (3) cycle(5'b11111, 0, 0);
    cycle(5'b11111, 1, 1);
    cycle(5'b11111, 0, 0);
    cycle(5'b00000, 0, 0);
    // random traffic: requests hold until yumi
    pend = '0;
    max_wait = 0;
    for (int i = 0; i < N; i++) pend_wait[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(1) == 1) begin
          pend[i] = 1'b1;
          req_packet[i] = '{rob_tag: 5'($urandom), value: $urandom};
        end
      valid_out_bus = pend;
      #1;
      n_yumi += $countones(yummi_in_bus);
      n_cdbv += int'(cdb_valid);
      for (int i = 0; i < N; i++)
        if (pend[i] && !yummi_in_bus[i]) begin
          pend_wait[i]++;
          if (pend_wait[i] > max_wait) max_wait = pend_wait[i];
        end
      pend = pend & ~yummi_in_bus;
      for (int i = 0; i < N; i++) if (!pend[i]) pend_wait[i] = 0;
      // cycle re-drives the same inputs and runs the full model compare
      cycle(valid_out_bus, 0, 0);
    end
    n_cdbv += int'(cdb_valid);
    cycle(5'b00000, 0, 0);
    chk("fairness_max_wait_le4", 64'(max_wait <= N - 1), 64'd1);
    chk("yumi_vs_cdb_valid", 64'(n_cdbv), 64'(n_yumi));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
